stream_producer: RTL and testbench



---
 rtl/stream_pkg.sv | 13 +
 rtl/stream_producer_sync_fifo.sv | 63 ++++++
 rtl/stream_producer.sv | 180 ++++++++++++++++++
 tb/tb_stream_producer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the XDRS stream producer: FSM encodings and data width.
// The state codes match the consumer-side cores so traces line up across blocks.
package stream_pkg;

    localparam int C_DATA_W = 32;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd15,
        S_WR    = 4'd2,
        S_RETRY = 4'd3
    } state_t;

endpackage

// File: rtl/stream_producer_sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// The head word is combinational from storage and forced to zero when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a push while full is
    // rejected even if a pop happens in the same cycle.
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_producer.sv
// Producer endpoint of the XDRS prdy/crdy/cerr stream protocol.
// Host pushes into a small FIFO; the FSM presents the head word, backs off
// on consumer errors, retries a bounded number of times, then drops the word.
module stream_producer
    import stream_pkg::*;
#(
    parameter int C_FIFO_AW     = 2,
    parameter int C_RETRY_DELAY = 16,
    parameter int C_MAX_RETRY   = 8,
    parameter int C_CNT_BW      = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [C_DATA_W-1:0] wr_data,
    output logic                wr_full,
    output logic                p_prdy,
    input  logic                p_crdy,
    input  logic                p_cerr,
    output logic [C_DATA_W-1:0] p_data,
    output logic [C_CNT_BW-1:0] xfer_cnt,
    output logic [C_CNT_BW-1:0] retry_cnt,
    output logic [C_CNT_BW-1:0] drop_cnt,
    output logic                ovf,
    output logic                idle
);

    localparam int ATT_W = (C_MAX_RETRY > 1) ? $clog2(C_MAX_RETRY) : 1;
    localparam logic [ATT_W-1:0]   LAST_ATT = ATT_W'(C_MAX_RETRY - 1);
    localparam logic [7:0]         LAST_DLY = 8'(C_RETRY_DELAY - 1);
    localparam logic [C_FIFO_AW:0] CNT_ONE  = (C_FIFO_AW+1)'(1);

    state_t               state;
    state_t               state_nxt;
    logic [C_FIFO_AW:0]   fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [C_DATA_W-1:0]  head;
    logic                 push;
    logic                 pop;
    logic                 nempty_q;
    logic [ATT_W-1:0]     attempt;
    logic [7:0]           delay;
    logic                 last_att;
    logic                 xfer_inc;
    logic                 retry_inc;
    logic                 drop_inc;

    assign push     = wr_en & ~fifo_full;
    assign wr_full  = fifo_full;
    assign p_data   = head;
    assign last_att = (attempt == LAST_ATT);
    assign idle     = (state == S_IDLE) && fifo_empty;

    sync_fifo #(
        .WIDTH (C_DATA_W),
        .AW    (C_FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One-cycle-old not-empty flag: leaving idle needs the word to have been
    // resident for a full cycle, so a fresh push is presented two edges later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nempty_q <= 1'b0;
        end else begin
            nempty_q <= ~fifo_empty;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode; crdy wins over cerr when both are seen.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (nempty_q && !fifo_empty) begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (p_crdy) begin
                    // Post-pop occupancy is count-1+push; count is at least 1 here.
                    state_nxt = ((fifo_count > CNT_ONE) || push) ? S_WR : S_IDLE;
                end else if (p_cerr) begin
                    state_nxt = last_att ? S_IDLE : S_RETRY;
                end
            end
            S_RETRY: begin
                if (delay == LAST_DLY) begin
                    state_nxt = S_WR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: presentation strobe, FIFO pop and statistics events.
    always_comb begin
        p_prdy    = 1'b0;
        pop       = 1'b0;
        xfer_inc  = 1'b0;
        retry_inc = 1'b0;
        drop_inc  = 1'b0;
        if (state == S_WR) begin
            p_prdy = 1'b1;
            if (p_crdy) begin
                pop      = 1'b1;
                xfer_inc = 1'b1;
            end else if (p_cerr) begin
                if (last_att) begin
                    pop      = 1'b1;
                    drop_inc = 1'b1;
                end else begin
                    retry_inc = 1'b1;
                end
            end
        end
    end

    // Attempt and back-off delay counters for the word at the FIFO head.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            attempt <= '0;
            delay   <= '0;
        end else begin
            if (xfer_inc || drop_inc) begin
                attempt <= '0;
            end else if (retry_inc) begin
                attempt <= attempt + 1'b1;
            end
            if (retry_inc) begin
                delay <= '0;
            end else if (state == S_RETRY) begin
                delay <= delay + 8'd1;
            end
        end
    end

    // Free-running statistics (wrap naturally) and sticky overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xfer_cnt  <= '0;
            retry_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (xfer_inc) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (drop_inc) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (wr_en && fifo_full) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_producer.sv
// Directed bench for stream_producer: a cycle table for the single-word
// latency case, then hand-written sequences for the multi-cycle corners.
module tb_stream_producer;

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_full;
    logic        p_prdy;
    logic        p_crdy;
    logic        p_cerr;
    logic [31:0] p_data;
    logic [31:0] xfer_cnt;
    logic [31:0] retry_cnt;
    logic [31:0] drop_cnt;
    logic        ovf;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr_en;
        logic [31:0] wr_data;
        logic        crdy;
        logic        cerr;
        logic        e_prdy;
        logic [31:0] e_data;
        logic [31:0] e_xfer;
        logic        e_idle;
        logic        e_full;
    } vec_t;

    vec_t vecs [6];

    stream_producer dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .p_prdy    (p_prdy),
        .p_crdy    (p_crdy),
        .p_cerr    (p_cerr),
        .p_data    (p_data),
        .xfer_cnt  (xfer_cnt),
        .retry_cnt (retry_cnt),
        .drop_cnt  (drop_cnt),
        .ovf       (ovf),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        p_crdy  = 1'b0;
        p_cerr  = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic wait_prdy(input int budget);
        int n = 0;
        while (!p_prdy && n < budget) begin
            tick();
            n++;
        end
        check("prdy_wait", 64'(p_prdy), 64'd1);
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int low;
        int pres;
        int saw;

        // prdy is seen two edges after the push edge, for one cycle.
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 32'h0,         32'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 32'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'd1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'd1, 1'b1, 1'b0};

        // Reset state
        do_reset();
        check("rst_prdy",  64'(p_prdy),    64'd0);
        check("rst_data",  64'(p_data),    64'd0);
        check("rst_full",  64'(wr_full),   64'd0);
        check("rst_xfer",  64'(xfer_cnt),  64'd0);
        check("rst_retry", 64'(retry_cnt), 64'd0);
        check("rst_drop",  64'(drop_cnt),  64'd0);
        check("rst_ovf",   64'(ovf),       64'd0);
        check("rst_idle",  64'(idle),      64'd1);

        // Single word, consumer always ready
        for (int i = 0; i < 6; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            p_crdy  = vecs[i].crdy;
            p_cerr  = vecs[i].cerr;
            #1;
            check($sformatf("v%0d_prdy", i), 64'(p_prdy),   64'(vecs[i].e_prdy));
            check($sformatf("v%0d_data", i), 64'(p_data),   64'(vecs[i].e_data));
            check($sformatf("v%0d_xfer", i), 64'(xfer_cnt), 64'(vecs[i].e_xfer));
            check($sformatf("v%0d_idle", i), 64'(idle),     64'(vecs[i].e_idle));
            check($sformatf("v%0d_full", i), 64'(wr_full),  64'(vecs[i].e_full));
            tick();
        end

        // Fill to full, overflow, then drain back to back
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push_word(32'(i));
        end
        check("fill_full", 64'(wr_full), 64'd1);
        check("fill_ovf0", 64'(ovf),     64'd0);
        push_word(32'd5);
        check("ovf_set",   64'(ovf),     64'd1);
        check("ovf_full",  64'(wr_full), 64'd1);
        p_crdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain%0d_prdy", i), 64'(p_prdy), 64'd1);
            check($sformatf("drain%0d_data", i), 64'(p_data), 64'(i));
            tick();
        end
        check("drain_prdy", 64'(p_prdy),   64'd0);
        check("drain_xfer", 64'(xfer_cnt), 64'd4);
        check("drain_idle", 64'(idle),     64'd1);
        check("drain_full", 64'(wr_full),  64'd0);
        check("drain_ovf",  64'(ovf),      64'd1);

        // One cerr: back off exactly 16 cycles; crdy/cerr ignored meanwhile
        do_reset();
        push_word(32'h10);
        wait_prdy(10);
        p_cerr = 1'b1;
        tick();
        p_crdy = 1'b1;
        low = 0;
        while (!p_prdy && low < 40) begin
            low++;
            tick();
        end
        check("retry_low",   64'(low),       64'd16);
        check("retry_data",  64'(p_data),    64'h10);
        check("retry_cnt1",  64'(retry_cnt), 64'd1);
        check("retry_xfer0", 64'(xfer_cnt),  64'd0);
        tick();
        p_crdy = 1'b0;
        p_cerr = 1'b0;
        check("retry_xfer1", 64'(xfer_cnt),  64'd1);
        check("retry_cnt2",  64'(retry_cnt), 64'd1);
        check("retry_prdy",  64'(p_prdy),    64'd0);

        // Every presentation errored: 8 attempts then drop
        do_reset();
        p_cerr = 1'b1;
        push_word(32'h20);
        pres = 0;
        for (int i = 0; i < 200; i++) begin
            if (p_prdy) begin
                pres++;
            end
            tick();
        end
        p_cerr = 1'b0;
        check("drop_pres",  64'(pres),      64'd8);
        check("drop_retry", 64'(retry_cnt), 64'd7);
        check("drop_cnt",   64'(drop_cnt),  64'd1);
        check("drop_xfer",  64'(xfer_cnt),  64'd0);
        check("drop_prdy",  64'(p_prdy),    64'd0);
        check("drop_idle",  64'(idle),      64'd1);
        check("drop_data",  64'(p_data),    64'd0);

        // crdy and cerr together: transfer wins
        do_reset();
        push_word(32'h30);
        wait_prdy(10);
        p_crdy = 1'b1;
        p_cerr = 1'b1;
        tick();
        p_crdy = 1'b0;
        p_cerr = 1'b0;
        check("both_xfer",  64'(xfer_cnt),  64'd1);
        check("both_retry", 64'(retry_cnt), 64'd0);
        check("both_prdy",  64'(p_prdy),    64'd0);

        // Reset while backing off with 3 words queued
        do_reset();
        push_word(32'h41);
        push_word(32'h42);
        push_word(32'h43);
        wait_prdy(10);
        p_cerr = 1'b1;
        tick();
        p_cerr = 1'b0;
        repeat (5) tick();
        check("mid_prdy",  64'(p_prdy),    64'd0);
        check("mid_retry", 64'(retry_cnt), 64'd1);
        check("mid_idle",  64'(idle),      64'd0);
        p_crdy = 1'b1;
        rstn   = 1'b0;
        #1;
        check("arst_prdy",  64'(p_prdy),    64'd0);
        check("arst_data",  64'(p_data),    64'd0);
        check("arst_retry", 64'(retry_cnt), 64'd0);
        check("arst_xfer",  64'(xfer_cnt),  64'd0);
        check("arst_idle",  64'(idle),      64'd1);
        check("arst_full",  64'(wr_full),   64'd0);
        tick();
        rstn = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            if (p_prdy) begin
                saw++;
            end
            tick();
        end
        check("post_rst_prdy", 64'(saw),      64'd0);
        check("post_rst_xfer", 64'(xfer_cnt), 64'd0);
        check("post_rst_idle", 64'(idle),     64'd1);
        push_word(32'h55);
        wait_prdy(10);
        check("post_rst_data", 64'(p_data),   64'h55);
        tick();
        p_crdy = 1'b0;
        check("post_rst_xfer1", 64'(xfer_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
